// File: rtl/flash_audio_reader_pkg.sv
// Shared types and defaults for the flash audio reader: FSM state encoding,
// clip bounds and the native sample width.
package flash_audio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      TICK1,
      TICK2,
      ADVANCE,
      RESTART
   } state_e;

   localparam int SAMPLE_W = 16;
   localparam int DEF_ADDR_W = 23;
   localparam logic [22:0] DEF_START_ADDR = 23'h000000;
   localparam logic [22:0] DEF_END_ADDR = 23'h07FFFF;

endpackage

// File: rtl/flash_audio_reader_if.sv
// Avalon-MM read-master bundle between the audio reader and the flash controller.
// Handshake: the master holds flash_read and flash_address steady until it sees
// flash_waitrequest low at a clock edge (request accepted); read data arrives later,
// qualified by a one-cycle flash_readdatavalid.
interface flash_audio_reader_if #(
   parameter int ADDR_W = 23
) ();
   logic              flash_read;
   logic [ADDR_W-1:0] flash_address;
   logic              flash_waitrequest;
   logic              flash_readdatavalid;
   logic [31:0]       flash_readdata;

   modport master (
      output flash_read, flash_address,
      input  flash_waitrequest, flash_readdatavalid, flash_readdata
   );

   modport slave (
      input  flash_read, flash_address,
      output flash_waitrequest, flash_readdatavalid, flash_readdata
   );
endinterface

// File: rtl/flash_addr_stepper.sv
// Next word address within the clip, wrapping at either end depending on direction.
module flash_addr_stepper #(
   parameter int                ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              dir,
   output logic [ADDR_W-1:0] next_addr
);
   always_comb begin
      next_addr = addr;
      if (dir) begin
         next_addr = (addr == END_ADDR) ? START_ADDR : addr + ADDR_W'(1);
      end else begin
         next_addr = (addr == START_ADDR) ? END_ADDR : addr - ADDR_W'(1);
      end
   end
endmodule

// File: rtl/flash_audio_reader.sv
// Fetches 32-bit words from flash and emits two samples per word on sample_tick.
// Define FLASH_READER_UNSIGNED_EN for offset-binary audio_out (sample MSB inverted).
module flash_audio_reader
   import flash_audio_pkg::*;
#(
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
   parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR,
   parameter int                OUT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 can_read,
   input  logic                 is_fwrd,
   input  logic                 restart,
   input  logic                 sample_tick,
   flash_audio_reader_if.master flash,
   output logic [OUT_W-1:0]     audio_out,
   output logic                 audio_valid,
   output logic                 read_done,
   output state_e               dbg_state
);
`ifdef FLASH_READER_UNSIGNED_EN
   localparam logic [OUT_W-1:0] AUDIO_RST = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] SIGN_FLIP = {1'b1, {(OUT_W-1){1'b0}}};
`else
   localparam logic [OUT_W-1:0] AUDIO_RST = '0;
   localparam logic [OUT_W-1:0] SIGN_FLIP = '0;
`endif

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, addr_step;
   logic                dir_q, dir_d;
   logic [31:0]         word_q, word_d;
   logic [OUT_W-1:0]    audio_q, audio_d;
   logic                valid_q, valid_d;
   logic                arm_q, arm_d;
   logic [SAMPLE_W-1:0] sample_sel;
   logic                restart_go;

   flash_addr_stepper #(
      .ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR)
   ) u_stepper (
      .addr(addr_q), .dir(dir_q), .next_addr(addr_step)
   );

   // A held restart is serviced once; it must go low before it can fire again.
   assign restart_go = restart && arm_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      dir_d      = dir_q;
      word_d     = word_q;
      audio_d    = audio_q;
      valid_d    = 1'b0;
      arm_d      = arm_q | ~restart;
      sample_sel = '0;
      case (state_q)
         IDLE: begin
            if (restart_go) begin
               state_d = RESTART;
            end else if (can_read) begin
               state_d = REQ;
               dir_d   = is_fwrd;
            end
         end
         REQ: begin
            if (!flash.flash_waitrequest) state_d = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (flash.flash_readdatavalid) begin
               word_d  = flash.flash_readdata;
               state_d = TICK1;
            end
         end
         TICK1, TICK2: begin
            if (restart_go) begin
               state_d = RESTART;
            end else if (can_read && sample_tick) begin
               // Forward plays low half first; backward plays high half first.
               sample_sel = ((state_q == TICK1) == dir_q) ? word_q[15:0] : word_q[31:16];
               audio_d    = sample_sel[SAMPLE_W-1 -: OUT_W] ^ SIGN_FLIP;
               valid_d    = 1'b1;
               state_d    = (state_q == TICK1) ? TICK2 : ADVANCE;
            end
         end
         ADVANCE: begin
            addr_d  = addr_step;
            state_d = IDLE;
         end
         RESTART: begin
            addr_d  = is_fwrd ? START_ADDR : END_ADDR;
            arm_d   = ~restart;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= START_ADDR;
         dir_q   <= 1'b1;
         word_q  <= '0;
         audio_q <= AUDIO_RST;
         valid_q <= 1'b0;
         arm_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dir_q   <= dir_d;
         word_q  <= word_d;
         audio_q <= audio_d;
         valid_q <= valid_d;
         arm_q   <= arm_d;
      end
   end

   assign flash.flash_read    = (state_q == REQ);
   assign flash.flash_address = addr_q;
   assign audio_out           = audio_q;
   assign audio_valid         = valid_q;
   assign read_done           = (state_q == RESTART);
   assign dbg_state           = state_q;

   generate
      if (OUT_W < SAMPLE_W) begin : g_lsb_sink
         logic unused_lsbs;
         assign unused_lsbs = ^sample_sel[SAMPLE_W-OUT_W-1:0];
      end
   endgenerate
endmodule

// File: tb/tb_flash_audio_reader.sv
// Bench for flash_audio_reader: table of word fetches plus restart, pause and reset sequences.
module tb_flash_audio_reader;
   import flash_audio_pkg::*;

   localparam logic [22:0] END_A = 23'h07FFFF;
`ifdef FLASH_READER_UNSIGNED_EN
   localparam logic [7:0] SGN_X = 8'h80;
`else
   localparam logic [7:0] SGN_X = 8'h00;
`endif

   typedef struct {
      logic        fwd;
      logic [22:0] addr;
      logic [31:0] word;
      logic [7:0]  s1;
      logic [7:0]  s2;
      int          stall;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       can_read = 1'b0, is_fwrd = 1'b1, restart = 1'b0, sample_tick = 1'b0;
   logic [7:0] audio_out;
   logic       audio_valid, read_done;
   state_e     dbg_state;

   flash_audio_reader_if #(.ADDR_W(23)) fif ();

   int          stall_cfg = 0, wait_cnt = 0, lat_cnt = 0;
   logic        rdv = 1'b0;
   logic [31:0] rdata = '0, cur_word = '0;

   int vecs = 0, fails = 0, audio_cnt = 0, rd_cnt = 0;
   logic [7:0]  exp_q[$];
   logic [22:0] exp_addr_q[$];
   logic prev_read = 1'b0, prev_wait = 1'b0, prev_rst = 1'b0;

   always #5 clk = ~clk;

   flash_audio_reader dut (
      .clk(clk), .reset_n(reset_n), .can_read(can_read), .is_fwrd(is_fwrd),
      .restart(restart), .sample_tick(sample_tick), .flash(fif.master),
      .audio_out(audio_out), .audio_valid(audio_valid), .read_done(read_done),
      .dbg_state(dbg_state)
   );

   assign fif.flash_waitrequest   = fif.flash_read && (wait_cnt < stall_cfg);
   assign fif.flash_readdatavalid = rdv;
   assign fif.flash_readdata      = rdata;

   // Flash slave: stalls stall_cfg cycles, returns cur_word two cycles after accept.
   always @(posedge clk) begin
      rdv <= 1'b0;
      if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
         rdv   <= 1'b1;
         rdata <= cur_word;
      end
      if (fif.flash_read && fif.flash_waitrequest) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
         if (fif.flash_read) lat_cnt <= 2;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (audio_valid) begin
            audio_cnt++;
            if (exp_q.size() == 0) begin
               vecs++; fails++;
               $display("FAIL audio_unexpected got %h expected none", audio_out);
            end else begin
               chk("audio_sample", {24'd0, audio_out}, {24'd0, exp_q.pop_front()});
            end
         end
         if (read_done) rd_cnt++;
         if (fif.flash_read && !fif.flash_waitrequest) begin
            if (exp_addr_q.size() == 0) begin
               vecs++; fails++;
               $display("FAIL read_unexpected got %h expected none", fif.flash_address);
            end else begin
               chk("fetch_addr", {9'd0, fif.flash_address}, {9'd0, exp_addr_q.pop_front()});
            end
         end
         if (prev_rst && prev_read && prev_wait && !fif.flash_read) begin
            vecs++; fails++;
            $display("FAIL read_dropped got flash_read=0 expected 1 under waitrequest");
         end
      end
      prev_read = fif.flash_read;
      prev_wait = fif.flash_waitrequest;
      prev_rst  = reset_n;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic tick_until(input int target, input int budget);
      int n = 0;
      int per = $urandom_range(3, 6);
      while (audio_cnt < target && n < budget) begin
         sample_tick = (n % per == per - 1);
         cyc();
         n++;
      end
      sample_tick = 1'b0;
      if (audio_cnt < target) begin
         vecs++; fails++;
         $display("FAIL tick_timeout got %0d pulses expected %0d", audio_cnt, target);
      end
   endtask

   task automatic wait_read(input int budget);
      int n = 0;
      while (!fif.flash_read && n < budget) begin
         cyc();
         n++;
      end
      if (!fif.flash_read) begin
         vecs++; fails++;
         $display("FAIL read_timeout got flash_read=0 expected 1");
      end
   endtask

   task automatic run_vec(input vec_t v);
      is_fwrd   = v.fwd;
      stall_cfg = v.stall;
      cur_word  = v.word;
      exp_addr_q.push_back(v.addr);
      exp_q.push_back(v.s1 ^ SGN_X);
      exp_q.push_back(v.s2 ^ SGN_X);
      can_read = 1'b1;
      tick_until(audio_cnt + 2, 300);
      can_read = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_flash_read"}, {31'd0, fif.flash_read}, 32'd0);
      chk({tag, "_flash_address"}, {9'd0, fif.flash_address}, 32'd0);
      chk({tag, "_audio_out"}, {24'd0, audio_out}, {24'd0, SGN_X});
      chk({tag, "_audio_valid"}, {31'd0, audio_valid}, 32'd0);
      chk({tag, "_read_done"}, {31'd0, read_done}, 32'd0);
      chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int a0, r0;
      vt[0] = '{1'b1, 23'h000000, 32'hAABB_CCDD, 8'hCC, 8'hAA, 0};
      vt[1] = '{1'b0, 23'h000001, 32'h5566_7788, 8'h55, 8'h77, 2};
      vt[2] = '{1'b0, 23'h000000, 32'h1122_3344, 8'h11, 8'h33, 1};
      vt[3] = '{1'b1, END_A,      32'h9ABC_DEF0, 8'hDE, 8'h9A, 0};
      vt[4] = '{1'b1, 23'h000000, 32'h7F00_8001, 8'h80, 8'h7F, 3};

      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();
      check_reset_outputs("reset");

      for (int i = 0; i < 5; i++) run_vec(vt[i]);

      // Pause in TICK2: ticks ignored, output held, resume plays second half.
      is_fwrd = 1'b1; stall_cfg = 1; cur_word = 32'h4433_2211;
      exp_addr_q.push_back(23'h000001);
      exp_q.push_back(8'h22 ^ SGN_X);
      exp_q.push_back(8'h44 ^ SGN_X);
      can_read = 1'b1;
      tick_until(audio_cnt + 1, 300);
      can_read = 1'b0;
      a0 = audio_cnt;
      for (int k = 0; k < 5; k++) begin
         sample_tick = 1'b1; cyc();
         sample_tick = 1'b0; cyc(); cyc();
      end
      chk("pause_no_valid", a0, audio_cnt);
      chk("pause_hold", {24'd0, audio_out}, {24'd0, 8'h22 ^ SGN_X});
      can_read = 1'b1;
      tick_until(audio_cnt + 1, 300);
      can_read = 1'b0;

      // Restart during a stalled fetch, switching to backward.
      stall_cfg = 3; is_fwrd = 1'b1; cur_word = 32'hDEAD_BEEF;
      exp_addr_q.push_back(23'h000002);
      exp_addr_q.push_back(END_A);
      can_read = 1'b1;
      wait_read(20);
      restart = 1'b1; is_fwrd = 1'b0;
      a0 = audio_cnt; r0 = rd_cnt;
      cur_word = 32'h0102_0304;
      for (int n = 0; n < 60 && rd_cnt == r0; n++) cyc();
      restart = 1'b0;
      chk("restart_done_seen", {31'd0, rd_cnt > r0}, 32'd1);
      chk("restart_no_audio", audio_cnt, a0);
      stall_cfg = 0;
      exp_q.push_back(8'h01 ^ SGN_X);
      exp_q.push_back(8'h03 ^ SGN_X);
      tick_until(audio_cnt + 2, 300);
      can_read = 1'b0;
      chk("read_done_width", rd_cnt, r0 + 1);

      // A restart held high yields a single read_done.
      r0 = rd_cnt;
      restart = 1'b1;
      repeat (10) cyc();
      restart = 1'b0;
      repeat (3) cyc();
      chk("restart_held_once", rd_cnt, r0 + 1);

      // Reset while the request is stalled.
      stall_cfg = 20; is_fwrd = 1'b1; can_read = 1'b1;
      wait_read(20);
      cyc(); cyc();
      chk("stall_holds_read", {31'd0, fif.flash_read}, 32'd1);
      reset_n = 1'b0; can_read = 1'b0;
      cyc();
      reset_n = 1'b1;
      check_reset_outputs("midreq_reset");
      stall_cfg = 0;
      repeat (6) cyc();

      chk("exp_audio_drained", exp_q.size(), 0);
      chk("exp_addr_drained", exp_addr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
